// File: rtl/mult_share_arbiter_if.sv
// Bus bundle between the requester/multiplier side and the shared-multiplier
// round-robin arbiter. The arbiter connects through the slave modport and the
// surrounding logic (or a testbench) connects through the master modport.
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_i;
    logic [4*N_REQ-1:0] a_i;
    logic [4*N_REQ-1:0] b_i;
    logic [N_REQ-1:0]   ack_o;
    logic [N_REQ-1:0]   rsp_valid_o;
    logic [7:0]         rsp_y_o;
    logic               rsp_err_o;
    logic               busy_o;
    logic               mul_ena_o;
    logic [3:0]         mul_a_o;
    logic [3:0]         mul_b_o;
    logic [7:0]         mul_y_i;
    logic               mul_done_i;
    logic [2:0]         state_o;

    modport slave (
        input  req_i, a_i, b_i, mul_y_i, mul_done_i,
        output ack_o, rsp_valid_o, rsp_y_o, rsp_err_o, busy_o,
               mul_ena_o, mul_a_o, mul_b_o, state_o
    );

    modport master (
        output req_i, a_i, b_i, mul_y_i, mul_done_i,
        input  ack_o, rsp_valid_o, rsp_y_o, rsp_err_o, busy_o,
               mul_ena_o, mul_a_o, mul_b_o, state_o
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential 4x4 multiplier among N_REQ
// requesters. Captures the winner's operands, starts the multiplier, waits for
// done (or a timeout) and returns the product to the winner.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arbiter_if.slave bus
);
    localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       TO_CNT  = 8'(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [3:0]       mul_a_q, mul_a_d;
    logic [3:0]       mul_b_q, mul_b_d;
    logic [7:0]       y_q, y_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] rsp_valid;
    logic             mul_ena;
    logic             busy;

    // Round-robin search: first requester strictly after the last winner, wrapping
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && bus.req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Operand mux for the candidate winner
    always_comb begin
        sel_a = 4'd0;
        sel_b = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_a = bus.a_i[4*k +: 4];
                sel_b = bus.b_i[4*k +: 4];
            end
        end
    end

    assign win_onehot = ONE << win_q;

    // Next-state and per-state pulse outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        y_d       = y_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ack       = '0;
        rsp_valid = '0;
        mul_ena   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (found) begin
                    win_d   = pick;
                    ptr_d   = pick;
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                ack     = win_onehot;
                state_d = S_START;
            end
            S_START: begin
                mul_ena = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A done arriving on the timeout cycle still delivers the product
                if (bus.mul_done_i) begin
                    y_d     = bus.mul_y_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q + 8'd1 == TO_CNT) begin
                    y_d     = 8'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = win_onehot;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            win_q   <= '0;
            mul_a_q <= 4'd0;
            mul_b_q <= 4'd0;
            y_q     <= 8'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            y_q     <= y_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ack_o       = ack;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_y_o     = y_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.busy_o      = busy;
    assign bus.mul_ena_o   = mul_ena;
    assign bus.mul_a_o     = mul_a_q;
    assign bus.mul_b_o     = mul_b_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: directed scenarios plus randomized rounds,
// checked against a transaction-level reference (round-robin pick, product or
// timeout, response latency) and a behavioural sequential multiplier.
module tb_mult_share_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N_REQ(N)) bus ();

    mult_share_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference state
    int         rr_ptr;
    logic [3:0] opa [N];
    logic [3:0] opb [N];

    // multiplier model controls
    int         mul_lat;
    bit         mul_never;
    int         mcnt;
    logic       model_done;
    logic [7:0] model_y;
    logic       stale_done;

    assign bus.mul_done_i = model_done | stale_done;
    assign bus.mul_y_i    = model_y;

    // Sequential multiplier: done pulse mul_lat cycles after start, unless disabled
    always @(negedge clk) begin
        if (bus.mul_ena_o === 1'b1) begin
            mcnt       = mul_lat;
            model_done = 1'b0;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0 && !mul_never) begin
                model_done = 1'b1;
                model_y    = {4'd0, bus.mul_a_o} * {4'd0, bus.mul_b_o};
            end else begin
                model_done = 1'b0;
            end
        end else begin
            model_done = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_ops(input int k, input logic [3:0] a, input logic [3:0] b);
        opa[k]             = a;
        opb[k]             = b;
        bus.a_i[4*k +: 4]  = a;
        bus.b_i[4*k +: 4]  = b;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.req_i   = '0;
        cyc();
        cyc();
        rst    = 1'b0;
        rr_ptr = N - 1;
    endtask

    // One full operation for requester w, starting from IDLE with its request up
    task automatic serve(input int w, input bit drop);
        int         n;
        bit         got;
        bit         eerr;
        int         eff;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [7:0] ey;
        ea   = opa[w];
        eb   = opb[w];
        eerr = mul_never || (mul_lat > TO);
        eff  = eerr ? TO : mul_lat;
        ey   = eerr ? 8'd0 : ({4'd0, ea} * {4'd0, eb});
        got  = 1'b0;
        for (n = 1; n <= 10; n++) begin
            cyc();
            if (bus.ack_o !== '0) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", 32'(got), 1);
        if (!got) return;
        check("ack_latency", n, 1);
        check("ack_onehot", 32'(bus.ack_o), 1 << w);
        check("grant_state", 32'(bus.state_o), 1);
        rr_ptr = w;
        if (drop) bus.req_i[w] = 1'b0;
        set_ops(w, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        cyc();
        check("mul_ena", 32'(bus.mul_ena_o), 1);
        check("mul_a", 32'(bus.mul_a_o), 32'(ea));
        check("mul_b", 32'(bus.mul_b_o), 32'(eb));
        check("ack_clear", 32'(bus.ack_o), 0);
        got = 1'b0;
        for (n = 1; n <= 40; n++) begin
            cyc();
            if (bus.rsp_valid_o !== '0) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_seen", 32'(got), 1);
        if (!got) return;
        check("rsp_latency", n, eff + 1);
        check("rsp_onehot", 32'(bus.rsp_valid_o), 1 << w);
        check("rsp_y", 32'(bus.rsp_y_o), 32'(ey));
        check("rsp_err", 32'(bus.rsp_err_o), 32'(eerr));
        cyc();
        check("idle_busy", 32'(bus.busy_o), 0);
        check("rsp_pulse", 32'(bus.rsp_valid_o), 0);
        check("y_held", 32'(bus.rsp_y_o), 32'(ey));
    endtask

    task automatic serve_all();
        int w;
        for (int guard = 0; guard < 2 * N; guard++) begin
            if (bus.req_i == '0) break;
            w = pick(bus.req_i);
            serve(w, 1'b1);
        end
        check("all_served", 32'(bus.req_i), 0);
    endtask

    initial begin
        bit got;
        rst        = 1'b1;
        bus.req_i  = '0;
        bus.a_i    = '0;
        bus.b_i    = '0;
        stale_done = 1'b0;
        model_done = 1'b0;
        model_y    = 8'd0;
        mcnt       = 0;
        mul_lat    = 3;
        mul_never  = 1'b0;
        for (int k = 0; k < N; k++) begin
            opa[k] = 4'd0;
            opb[k] = 4'd0;
        end

        // reset state
        do_reset();
        check("rst_state", 32'(bus.state_o), 0);
        check("rst_ack", 32'(bus.ack_o), 0);
        check("rst_rspv", 32'(bus.rsp_valid_o), 0);
        check("rst_y", 32'(bus.rsp_y_o), 0);
        check("rst_err", 32'(bus.rsp_err_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_ena", 32'(bus.mul_ena_o), 0);
        check("rst_mula", 32'(bus.mul_a_o), 0);
        check("rst_mulb", 32'(bus.mul_b_o), 0);

        // single request 3*5
        set_ops(0, 4'd3, 4'd5);
        bus.req_i = 4'b0001;
        serve(pick(bus.req_i), 1'b1);

        // all four together, fresh pointer
        do_reset();
        set_ops(0, 4'd2, 4'd3);
        set_ops(1, 4'd4, 4'd5);
        set_ops(2, 4'd6, 4'd7);
        set_ops(3, 4'd15, 4'd15);
        bus.req_i = 4'b1111;
        serve_all();

        // fairness: 0 and 2 held high
        do_reset();
        set_ops(0, 4'd1, 4'd2);
        set_ops(2, 4'd3, 4'd4);
        bus.req_i = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            check("fair_order", pick(bus.req_i), ((i % 2) == 0) ? 0 : 2);
            serve(pick(bus.req_i), 1'b0);
            if (i == 3) bus.req_i = '0;
        end

        // timeout, then a normal 4*4
        mul_never = 1'b1;
        set_ops(0, 4'd7, 4'd8);
        bus.req_i = 4'b0001;
        serve(pick(bus.req_i), 1'b1);
        mul_never = 1'b0;
        mul_lat   = 2;
        set_ops(0, 4'd4, 4'd4);
        bus.req_i = 4'b0001;
        serve(pick(bus.req_i), 1'b1);

        // reset in the middle of WAIT
        mul_never = 1'b1;
        mul_lat   = 3;
        set_ops(0, 4'd7, 4'd7);
        bus.req_i = 4'b0001;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            if (bus.ack_o !== '0) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_ack_seen", 32'(got), 1);
        bus.req_i = '0;
        cyc();
        cyc();
        cyc();
        check("mid_in_wait", 32'(bus.state_o), 3);
        rst = 1'b1;
        cyc();
        check("mid_rst_state", 32'(bus.state_o), 0);
        check("mid_rst_busy", 32'(bus.busy_o), 0);
        check("mid_rst_y", 32'(bus.rsp_y_o), 0);
        check("mid_rst_err", 32'(bus.rsp_err_o), 0);
        check("mid_rst_mula", 32'(bus.mul_a_o), 0);
        check("mid_rst_mulb", 32'(bus.mul_b_o), 0);
        check("mid_rst_outs", 32'({bus.ack_o, bus.rsp_valid_o, bus.mul_ena_o}), 0);
        rst        = 1'b0;
        rr_ptr     = N - 1;
        mul_never  = 1'b0;
        stale_done = 1'b1;
        cyc();
        stale_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("stale_done_rspv", 32'(bus.rsp_valid_o), 0);
            check("stale_done_busy", 32'(bus.busy_o), 0);
            cyc();
        end
        set_ops(1, 4'd9, 4'd9);
        bus.req_i = 4'b0010;
        serve(pick(bus.req_i), 1'b1);

        // done coincides with the timeout cycle
        mul_lat = TO;
        set_ops(2, 4'd10, 4'd10);
        bus.req_i = 4'b0100;
        serve(pick(bus.req_i), 1'b1);

        // randomized rounds
        for (int r = 0; r < 15; r++) begin
            mul_lat = $urandom_range(1, 20);
            for (int k = 0; k < N; k++) begin
                set_ops(k, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            bus.req_i = 4'($urandom_range(1, 15));
            serve_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
